// File: rtl/axilite_bk_pkg.sv
// Shared types and widths for the backend register-port arbiter.
package axilite_bk_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_W = 2'd1,
        ISSUE_R = 2'd2,
        WAIT_R  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axilite_bk_arbiter_picker.sv
// Combinational round-robin picker: first pending requester at or above ptr, with wrap.
module bk_rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset back toward ptr so the nearest pending requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (pend[cand]) begin
                gnt_idx = cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axilite_bk_arbiter.sv
// Shares one pulse-style backend register port between N_REQ requesters.
// Start pulses are parked in per-requester slots and issued one at a time in
// round-robin order; read data is routed back to the requester that asked.
module axilite_bk_arbiter
    import axilite_bk_pkg::*;
#(
    parameter int                N_REQ    = 2,
    parameter int                TIMEOUT  = 256,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                      axi_aclk,
    input  logic                      axi_reset,
    input  logic                      arb_en,
    input  logic [N_REQ-1:0]          req_wstart,
    input  logic [N_REQ*ADDR_W-1:0]   req_waddr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    input  logic [N_REQ*STRB_W-1:0]   req_wstrb,
    input  logic [N_REQ-1:0]          req_rstart,
    input  logic [N_REQ*ADDR_W-1:0]   req_raddr,
    output logic [N_REQ*DATA_W-1:0]   req_rdata,
    output logic [N_REQ-1:0]          req_rdone,
    output logic                      tgt_wstart,
    output logic [ADDR_W-1:0]         tgt_waddr,
    output logic [DATA_W-1:0]         tgt_wdata,
    output logic [STRB_W-1:0]         tgt_wstrb,
    output logic                      tgt_rstart,
    output logic [ADDR_W-1:0]         tgt_raddr,
    input  logic [DATA_W-1:0]         tgt_rdata,
    input  logic                      tgt_rdone,
    output logic [N_REQ-1:0]          err_ovf,
    output logic                      err_tmo
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t state_q, state_d;

    logic [IDX_W-1:0] gnt_q, ptr_q, ptr_next, pick_idx;
    logic             pick_vld;

    logic [N_REQ-1:0] wpend_q, rpend_q;
    logic [N_REQ-1:0] w_load, r_load, w_take, r_take;

    logic [N_REQ-1:0][ADDR_W-1:0] wslot_addr_q, rslot_addr_q;
    logic [N_REQ-1:0][DATA_W-1:0] wslot_data_q;
    logic [N_REQ-1:0][STRB_W-1:0] wslot_strb_q;
    logic [N_REQ-1:0][DATA_W-1:0] rdata_q;

    logic [CNT_W-1:0] tmo_cnt_q;

    logic issue_w, issue_r, take_w, take_r, rd_ok, rd_tmo;

    bk_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .pend    (wpend_q | rpend_q),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    assign req_rdata = rdata_q;
    assign ptr_next  = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);

    // Arbiter FSM next state; grants only start from IDLE with arb_en high.
    always_comb begin
        state_d = state_q;
        issue_w = 1'b0;
        issue_r = 1'b0;
        take_w  = 1'b0;
        take_r  = 1'b0;
        rd_ok   = 1'b0;
        rd_tmo  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_en && pick_vld) begin
                    if (wpend_q[pick_idx]) begin
                        issue_w = 1'b1;
                        state_d = ISSUE_W;
                    end else begin
                        issue_r = 1'b1;
                        state_d = ISSUE_R;
                    end
                end
            end
            ISSUE_W: begin
                take_w  = 1'b1;
                state_d = IDLE;
            end
            ISSUE_R: begin
                take_r  = 1'b1;
                state_d = WAIT_R;
            end
            WAIT_R: begin
                if (tgt_rdone) begin
                    rd_ok   = 1'b1;
                    state_d = IDLE;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rd_tmo  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-slot load/consume decisions; a new start wins over same-cycle consumption.
    always_comb begin
        w_take = '0;
        r_take = '0;
        w_load = '0;
        r_load = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_take[i] = take_w && (gnt_q == IDX_W'(i));
            r_take[i] = take_r && (gnt_q == IDX_W'(i));
            w_load[i] = req_wstart[i] && (!wpend_q[i] || w_take[i]);
            r_load[i] = req_rstart[i] && (!rpend_q[i] || r_take[i]);
        end
    end

    // Control state, slot occupancy, sticky flags and registered outputs.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            wpend_q    <= '0;
            rpend_q    <= '0;
            tmo_cnt_q  <= '0;
            tgt_wstart <= 1'b0;
            tgt_waddr  <= '0;
            tgt_wdata  <= '0;
            tgt_wstrb  <= '0;
            tgt_rstart <= 1'b0;
            tgt_raddr  <= '0;
            req_rdone  <= '0;
            rdata_q    <= '0;
            err_ovf    <= '0;
            err_tmo    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue_w || issue_r) gnt_q <= pick_idx;
            if (take_w || rd_ok || rd_tmo) ptr_q <= ptr_next;

            wpend_q <= w_load | (wpend_q & ~w_take);
            rpend_q <= r_load | (rpend_q & ~r_take);
            err_ovf <= err_ovf | (req_wstart & ~w_load) | (req_rstart & ~r_load);

            if (take_r) tmo_cnt_q <= '0;
            else if (state_q == WAIT_R) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);

            tgt_wstart <= issue_w;
            tgt_waddr  <= issue_w ? wslot_addr_q[pick_idx] : '0;
            tgt_wdata  <= issue_w ? wslot_data_q[pick_idx] : '0;
            tgt_wstrb  <= issue_w ? wslot_strb_q[pick_idx] : '0;
            tgt_rstart <= issue_r;
            tgt_raddr  <= issue_r ? rslot_addr_q[pick_idx] : '0;

            req_rdone <= '0;
            if (rd_ok || rd_tmo) begin
                req_rdone[gnt_q] <= 1'b1;
                rdata_q[gnt_q]   <= rd_ok ? tgt_rdata : ERR_DATA;
            end
            if (rd_tmo) err_tmo <= 1'b1;
        end
    end

    // Slot payloads; occupancy lives in the pend vectors, so these need no reset.
    always_ff @(posedge axi_aclk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (w_load[i]) begin
                wslot_addr_q[i] <= req_waddr[i*ADDR_W +: ADDR_W];
                wslot_data_q[i] <= req_wdata[i*DATA_W +: DATA_W];
                wslot_strb_q[i] <= req_wstrb[i*STRB_W +: STRB_W];
            end
            if (r_load[i]) begin
                rslot_addr_q[i] <= req_raddr[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: doc/axilite_bk_arbiter.md
Name: axilite_bk_arbiter

Overview:
- Shares one backend register-access port between N_REQ requesters. Each requester is an AXI-Lite slave backend using pulse-style wstart/rstart and rdone.
- Captures each requester's start pulses into pending slots. Issues them one at a time in round-robin order onto the target backend, and routes read data back to the originator.
- A read timeout guarantees forward progress if the target never asserts rdone.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- TIMEOUT, 256, cycles to wait for tgt_rdone before returning an error read
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on a read timeout

Ports:
- axi_aclk  in  1  clock
- axi_reset  in  1  synchronous, active-high reset
- arb_en  in  1  grant enable; when low no new grant starts, but pending slots still fill and an in-flight read still completes
- req_wstart  in  N_REQ  per-requester one-cycle write start pulse
- req_waddr  in  N_REQ*15  per-requester write address, valid with req_wstart
- req_wdata  in  N_REQ*32  per-requester write data
- req_wstrb  in  N_REQ*4  per-requester byte strobes
- req_rstart  in  N_REQ  per-requester one-cycle read start pulse
- req_raddr  in  N_REQ*15  per-requester read address
- req_rdata  out  N_REQ*32  read data, valid with req_rdone
- req_rdone  out  N_REQ  one-cycle read completion pulse to the originator
- tgt_wstart  out  1  write start pulse to the target
- tgt_waddr  out  15  write address to the target
- tgt_wdata  out  32  write data to the target
- tgt_wstrb  out  4  byte strobes to the target
- tgt_rstart  out  1  read start pulse to the target
- tgt_raddr  out  15  read address to the target
- tgt_rdata  in  32  read data from the target
- tgt_rdone  in  1  read completion from the target
- err_ovf  out  N_REQ  sticky: a start pulse was dropped because its slot was full
- err_tmo  out  1  sticky: a read timed out

Behaviour:
- Reset:
  - All outputs are 0; all pending slots are cleared; the FSM enters IDLE; the round-robin pointer is 0.
  - Sticky flags are cleared only by reset.
  - Reset in the middle of a read abandons it. A late tgt_rdone after reset is ignored.
- Capture:
  - Each requester has one write slot (addr, data, strb) and one read slot (addr).
  - A start pulse loads its slot at the next edge.
  - If the start arrives while the slot is full and the slot is not being consumed that cycle, the pulse is dropped and err_ovf[i] is set.
  - Start in the same cycle as consumption of that slot: the new request is loaded (set wins).
- FSM states: IDLE, ISSUE_W, ISSUE_R, WAIT_R.
  - IDLE: if arb_en is high and any slot is pending, select requester g, the first requester with any pending slot searching from the pointer upward with wrap. Go to ISSUE_W if g's write slot is full, else ISSUE_R (write-before-read within a requester).
  - ISSUE_W: tgt_wstart=1 with the slot's addr/data/strb for exactly one cycle. Clear the slot, set pointer=(g+1) mod N_REQ, return to IDLE. Writes are posted: there is no completion.
  - ISSUE_R: tgt_rstart=1 with tgt_raddr for one cycle. Clear the slot, clear the timeout counter, go to WAIT_R.
  - WAIT_R: on tgt_rdone, register req_rdata[g]=tgt_rdata and pulse req_rdone[g] the next cycle. Set pointer=(g+1) mod N_REQ, go to IDLE.
  - WAIT_R timeout: if the counter reaches TIMEOUT-1 with no tgt_rdone, do the same with data ERR_DATA and set err_tmo.
- Target outputs: all registered. tgt_waddr/wdata/wstrb/raddr are 0 whenever their start signal is low.
- Latency: req_wstart high in cycle t gives tgt_wstart high in cycle t+2 when the arbiter is idle. tgt_rdone in cycle t gives req_rdone in cycle t+1.
- Stray input: tgt_rdone outside WAIT_R is ignored.
- Throughput: at most one target transaction in flight; the minimum issue spacing is 2 cycles.

Decomposition:
- Package axilite_bk_pkg:
  - State enum typedef.
  - Address width 15, data width 32, strobe width 4.
  - ERR_DATA default.
- Sub-module bk_rr_picker: combinational round-robin selection. Inputs are the pending vector and the pointer; outputs are the grant index and a valid flag.

Test Plan:
- Single write: req_wstart[0] with addr 0x0010, data 0x1234_5678, strb 0xF -> two cycles later one tgt_wstart pulse with the same values, and no req_rdone.
- Read: req_rstart[1] with addr 0x0020; target returns tgt_rdone 5 cycles after tgt_rstart with data 0xCAFE_0001 -> req_rdone[1] pulse with that data one cycle later, and req_rdone[0] stays 0.
- Fairness: both requesters post writes every cycle they can, 8 each -> target order alternates 0,1,0,1 and no err_ovf.
- Write-before-read: requester 0 write 0x30=0xA5 and read 0x30 in the same cycle -> tgt_wstart precedes tgt_rstart.
- Timeout: read with tgt_rdone never asserted -> after TIMEOUT cycles req_rdone with 0xDEAD_BEEF and err_tmo=1; a later stray tgt_rdone is ignored.
- Overflow/reset: two req_wstart[0] pulses while arb_en=0 -> err_ovf[0]=1. Assert axi_reset during WAIT_R -> all outputs 0, flags cleared, late tgt_rdone produces no req_rdone.
